// File: rtl/multiplier_seq.sv
// Sequential signed multiply-accumulate: p = m*b + r, one shift-add step per clock.
// Rebuilds a dividend from quotient/divisor/remainder; ovf flags a result wider than N bits.
module multiplier_seq #(
  parameter int unsigned N = 5
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           start_i,
  input  logic [N-1:0]   m_i,
  input  logic [N-1:0]   b_i,
  input  logic [N-1:0]   r_i,
  output logic [2*N-1:0] p_o,
  output logic           busy_o,
  output logic           valid_o,
  output logic           ovf_o
);

  localparam int unsigned W    = 2 * N;
  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e          state_q;
  logic            sign_q;
  logic [W-1:0]    r_ext_q;
  logic [W-1:0]    acc_q;
  logic [W-1:0]    mcand_q;
  logic [N-1:0]    mplier_q;
  logic [CntW-1:0] count_q;
  logic [W-1:0]    p_q;
  logic            valid_q;
  logic            ovf_q;

  logic [N-1:0]    mag_m;
  logic [N-1:0]    mag_b;
  logic [W-1:0]    p_d;
  logic [N:0]      p_top;
  logic            ovf_d;

  // The most negative operand negates onto itself, which reads correctly as unsigned 2^(N-1).
  always_comb begin
    mag_m = m_i[N-1] ? (~m_i + N'(1)) : m_i;
    mag_b = b_i[N-1] ? (~b_i + N'(1)) : b_i;
    p_d   = (sign_q ? (~acc_q + W'(1)) : acc_q) + r_ext_q;
    p_top = p_d[W-1:N-1];
    ovf_d = !((&p_top) || !(|p_top));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      r_ext_q  <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      p_q      <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_i) begin
            sign_q   <= m_i[N-1] ^ b_i[N-1];
            r_ext_q  <= {{N{r_i[N-1]}}, r_i};
            acc_q    <= '0;
            mcand_q  <= {{N{1'b0}}, mag_m};
            mplier_q <= mag_b;
            count_q  <= CntW'(N);
            state_q  <= StRun;
          end
        end
        StRun: begin
          if (mplier_q[0]) begin
            acc_q <= acc_q + mcand_q;
          end
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q - CntW'(1);
          if (count_q == CntW'(1)) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          p_q     <= p_d;
          ovf_q   <= ovf_d;
          valid_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign p_o     = p_q;
  assign busy_o  = (state_q != StIdle);
  assign valid_o = valid_q;
  assign ovf_o   = ovf_q;

endmodule

// File: doc/multiplier_seq.md
# multiplier_seq

Sequential signed multiply-accumulate unit computing p = m*b + r over N-bit two's-complement operands, one shift-add step per clock. It is the reconstruction counterpart of the sequential divider. Fed a quotient m, a divisor b and a remainder r, it regenerates the dividend. `ovf` flags whether that dividend fits back in N bits. It shares the divider's start/busy/valid handshake style so both can sit on the same operand bus for self-check.

## Interface
- N, default 5: operand width in bits, two's complement; legal N >= 2.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- start  input  1  request; sampled only in IDLE.
- m  input  N  signed multiplicand (quotient); captured on accepted start.
- b  input  N  signed multiplier (divisor); captured on accepted start.
- r  input  N  signed addend (remainder); captured on accepted start.
- p  output  2N  signed result m*b + r; holds last value until next result or reset.
- busy  output  1  high while an operation is in progress.
- valid  output  1  one-cycle pulse when p and ovf are updated.
- ovf  output  1  p outside [-2^(N-1), 2^(N-1)-1]; qualified by valid, held with p.

## Operation
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 at an edge: capture sign = m[N-1]^b[N-1], r sign-extended to 2N.
  - Capture mag_m = |m| and mag_b = |b| as N-bit unsigned (~x+1 when negative). -2^(N-1) maps to unsigned 2^(N-1), which is correct.
  - Clear acc (2N bits) and mcand = zero-extended mag_m; count = N; go RUN.
- RUN, per edge:
  - if mplier[0], acc = acc + mcand; then mcand = mcand << 1, mplier = mplier >> 1, count = count - 1.
  - After the N-th step, go FIX.
- FIX, one edge: p = (sign ? -acc : acc) + r_ext; ovf = (p[2N-1:N-1] not all equal); valid = 1; go IDLE.
- Width rule: |m*b| <= 2^(2N-2), |r| <= 2^(N-1), so p never wraps in 2N bits; no saturation.
- Zero operands are legal: m=0 or b=0 gives p = r_ext. There is no error state.
- start while busy (RUN/FIX) is ignored; the operands are not re-captured.
- Inputs m, b, r may change freely after the capture edge.

## Timing
- Reset (rst=0, async, any state): state=IDLE, p=0, busy=0, valid=0, ovf=0, count=0, acc=0. Takes effect immediately, not on clk.
- Reset mid-operation aborts: no valid pulse; the in-flight result is lost.
- Edge 0 (start accepted): busy=1 from just after edge 0.
- Edges 1..N: RUN steps.
- Edge N+1: FIX. After this edge valid=1, busy=0, p/ovf updated.
- Latency: start edge to valid = N+1 cycles. valid is high for exactly one cycle.
- Back-to-back: start=1 in the cycle where valid=1 is accepted at the next edge (state is IDLE). Throughput is one result per N+2 cycles.
- valid is cleared on the edge after it rises unless reset clears it first.

## Test plan
- N=5, m=3, b=4, r=1, start 1 cycle -> busy high 6 cycles; valid exactly 6 edges after start edge; p=13; ovf=0.
- m=-3, b=4, r=-1 -> p=-13 (10'b1111110011); ovf=0. Also m=2, b=-5, r=3 -> p=-7; ovf=0.
- Corner m=-16, b=-16, r=0 -> p=256; ovf=1. Also m=-16, b=1, r=0 -> p=-16; ovf=0. And m=0, b=-9, r=-4 -> p=-4; ovf=0.
- Toggle m/b/r and pulse start during RUN -> ignored. Result matches the first captured operands, and exactly one valid pulse occurs.
- Drive rst=0 mid-cycle during RUN step 3 -> busy, valid, p and ovf go to 0 without a clk edge. After release, the next start completes normally with no stale valid.
- Random sweep of all 32x32 m,b with random r, back-to-back starts -> every p equals m*b+r, and ovf matches the range check.
